vga_frame_renderer: RTL
=======================

// Module: vga_frame_renderer
// PURPOSE
//  Pixel stage directly downstream of the VGA timing generator. Takes the registered pixel_x/pixel_y/
//  display_on/hsync/vsync stream, fetches a 4-bit palette index from a double-buffered 160x120
//  framebuffer (2x pixel scaling to 320x240), maps it through a 16-entry 12-bit palette and drives the
//  pins. Swaps front/back buffers only during vertical sync, so frames never tear.
// PARAMETERS
//  FB_W        160    framebuffer width in pixels (display width / 2)
//  FB_H        120    framebuffer height in pixels (display height / 2)
//  ADDR_W      16     framebuffer address width; one buffer occupies FB_W*FB_H words
//  PIPE_LAT    3      clk cycles from pixel_x/pixel_y in to rgb_out; fixed, do not override
// PORTS
//  clk          in   1   25 MHz pixel clock
//  reset        in   1   asynchronous, active-high
//  pixel_x      in   10  current column from timing generator
//  pixel_y      in   10  current row from timing generator
//  display_on   in   1   active-video flag, aligned with pixel_x/pixel_y
//  hsync_in     in   1   active-low hsync, aligned with pixel_x/pixel_y
//  vsync_in     in   1   active-low vsync, aligned with pixel_x/pixel_y
//  fb_rd_addr   out  16  framebuffer read address (registered)
//  fb_rd_data   in   4   palette index; valid exactly 1 cycle after fb_rd_addr changes
//  pal_we       in   1   palette write strobe
//  pal_addr     in   4   palette entry to write
//  pal_data     in   12  RGB 4-4-4 value to write
//  swap_req     in   1   1-cycle pulse: writer has finished the back buffer
//  swap_ack     out  1   1-cycle pulse: swap performed
//  back_buf     out  1   index of the buffer the writer may draw into (= ~front_buf)
//  hsync_out    out  1   hsync_in delayed by PIPE_LAT
//  vsync_out    out  1   vsync_in delayed by PIPE_LAT
//  de_out       out  1   display_on delayed by PIPE_LAT
//  rgb_out      out  12  pixel colour; 0 when de_out is low
// BEHAVIOUR
//  Reset: fb_rd_addr=0, rgb_out=0, de_out=0, hsync_out=1, vsync_out=1, swap_ack=0, front_buf=0
//   (back_buf=1), swap pending=0, sync/de delay lines filled with idle values (1,1,0).
//   Palette entry i resets to {i,i,i} (grey ramp).
//  Pipeline: C0 inputs sampled -> C1 fb_rd_addr registered -> C2 fb_rd_data returned and registered
//   with the delayed de -> C3 palette lookup registered onto rgb_out. hsync/vsync/de pass through a
//   3-deep shift register, so every output is cycle-aligned with rgb_out.
//  Address: front_buf*FB_W*FB_H + (pixel_y>>1)*FB_W + (pixel_x>>1), computed modulo 2^16.
//   FB_W*row is built with shifts and adds ((r<<7)+(r<<5)); no multiplier.
//   Outside the active area (display_on=0), fb_rd_addr holds its previous value.
//  Blanking: rgb_out=0 whenever the delayed display_on is 0, regardless of fb_rd_data.
//  Palette: a write lands on the clk edge where pal_we=1. A C3 lookup of the same entry on that edge
//   returns the old value; the new value is visible from the next cycle.
//  Swap FSM, states IDLE/PENDING:
//   - IDLE: swap_req=1 -> PENDING.
//   - PENDING: on a vsync_in falling edge (previous sample 1, current 0), toggle front_buf, pulse
//     swap_ack for 1 cycle, return to IDLE.
//   - swap_req asserted in IDLE in the same cycle as a vsync falling edge is honoured at that edge.
//   - Extra swap_req while PENDING is ignored: one toggle per edge, at most one per frame.
//   - front_buf never changes outside that edge, so a visible frame reads one buffer throughout.
//  Reset mid-operation: all state returns to reset values immediately. A pending swap is discarded,
//   with no swap_ack. The first valid rgb_out comes PIPE_LAT cycles after reset drops.
// STRUCTURE
//  vga_pkg: FB_W, FB_H, PIPE_LAT, RGB_W=12, IDX_W=4, swap-state enum {S_IDLE, S_PENDING}.
//  Sub-module vga_palette: 16x12 register file, synchronous write and registered read, holds reset
//   grey ramp. Address generation, delay line and swap FSM stay in this module.
// TESTING
//  1 Drive pixel (0,0), display_on=1 -> fb_rd_addr=0 after 1 clk; data 4'h5 -> rgb_out=12'h555 at C3.
//  2 Pixel (319,239), front_buf=0 -> fb_rd_addr=119*160+159=19199; after a swap, same pixel -> 38399.
//  3 Write pal[5]=12'hF00 during streaming -> same-edge lookup of 5 gives 12'h555, next cycle 12'hF00.
//  4 swap_req mid-frame -> no toggle until vsync_in 1->0; then back_buf 1->0 and one swap_ack
//    pulse; a second swap_req in the same frame produces no extra toggle.
//  5 display_on=0 with fb_rd_data=4'hF -> rgb_out=0; hsync/vsync/de_out equal inputs delayed 3 cycles.
//  6 reset asserted with a swap PENDING mid-line -> outputs take reset values at once, no swap_ack;
//    normal output resumes 3 cycles after reset drops.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, swap-state encoding and palette helpers for the VGA pixel stage.
package vga_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int ADDR_W   = 16;
  localparam int PIPE_LAT = 3;
  localparam int RGB_W    = 12;
  localparam int IDX_W    = 4;
  localparam int PAL_N    = 16;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } swap_state_e;

  // Reset contents of a palette entry: equal R, G and B nibbles give a grey ramp.
  function automatic logic [RGB_W-1:0] grey_of(input logic [IDX_W-1:0] idx);
    return {idx, idx, idx};
  endfunction

endpackage

// File: rtl/vga_palette.sv
// 16-entry RGB 4-4-4 palette: synchronous write, registered (blankable) read.
module vga_palette
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [RGB_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  input  logic             rd_en,
  output logic [RGB_W-1:0] rdata
);

  logic [RGB_W-1:0] mem_q [PAL_N];
  logic [RGB_W-1:0] mem_d [PAL_N];
  logic [RGB_W-1:0] rdata_q;
  logic [RGB_W-1:0] rdata_d;

  // Reads use mem_q, so a lookup on the write edge still sees the old entry.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
    rdata_d = rd_en ? mem_q[raddr] : {RGB_W{1'b0}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PAL_N; i++) begin
        mem_q[i] <= grey_of(IDX_W'(i));
      end
      rdata_q <= {RGB_W{1'b0}};
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vga_frame_renderer.sv
// VGA pixel stage: double-buffered framebuffer fetch, palette map and tear-free buffer swap.
module vga_frame_renderer
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              display_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [IDX_W-1:0]  fb_rd_data,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_addr,
  input  logic [RGB_W-1:0]  pal_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              back_buf,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              de_out,
  output logic [RGB_W-1:0]  rgb_out
);

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PIPE_LAT-1:0] hs_dly_q, hs_dly_d;
  logic [PIPE_LAT-1:0] vs_dly_q, vs_dly_d;
  logic [PIPE_LAT-1:0] de_dly_q, de_dly_d;
  swap_state_e         state_q, state_d;
  logic                front_q, front_d;
  logic                ack_q, ack_d;
  logic                vs_prev_q, vs_prev_d;
  logic [ADDR_W-1:0]   row_s, col_s, base_s;
  logic                vs_fall_s;
  logic                unused_lsb_s;

  assign unused_lsb_s = pixel_x[0] ^ pixel_y[0];

  // Halve coordinates for 2x scaling; row*160 = (row<<7)+(row<<5), all modulo 2^16.
  always_comb begin
    row_s    = ADDR_W'(pixel_y[9:1]);
    col_s    = ADDR_W'(pixel_x[9:1]);
    base_s   = front_q ? ADDR_W'(FB_W * FB_H) : {ADDR_W{1'b0}};
    addr_d   = addr_q;
    if (display_on) begin
      addr_d = base_s + (row_s << 7) + (row_s << 5) + col_s;
    end else begin
      addr_d = addr_q;
    end
    idx_d    = fb_rd_data;
    hs_dly_d = {hs_dly_q[PIPE_LAT-2:0], hsync_in};
    vs_dly_d = {vs_dly_q[PIPE_LAT-2:0], vsync_in};
    de_dly_d = {de_dly_q[PIPE_LAT-2:0], display_on};
  end

  // Swap FSM: a request is only honoured on a vsync falling edge, one toggle per edge.
  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    ack_d     = 1'b0;
    vs_prev_d = vsync_in;
    vs_fall_s = vs_prev_q & ~vsync_in;
    case (state_q)
      S_IDLE: begin
        if (swap_req && vs_fall_s) begin
          front_d = ~front_q;
          ack_d   = 1'b1;
        end else if (swap_req) begin
          state_d = S_PENDING;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PENDING: begin
        if (vs_fall_s) begin
          front_d = ~front_q;
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_PENDING;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= {ADDR_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      hs_dly_q  <= {PIPE_LAT{1'b1}};
      vs_dly_q  <= {PIPE_LAT{1'b1}};
      de_dly_q  <= {PIPE_LAT{1'b0}};
      state_q   <= S_IDLE;
      front_q   <= 1'b0;
      ack_q     <= 1'b0;
      vs_prev_q <= 1'b1;
    end else begin
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      hs_dly_q  <= hs_dly_d;
      vs_dly_q  <= vs_dly_d;
      de_dly_q  <= de_dly_d;
      state_q   <= state_d;
      front_q   <= front_d;
      ack_q     <= ack_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  // The palette read is gated by de of the fetched pixel, so blanking lands on rgb_out.
  vga_palette u_palette (
    .clk   (clk),
    .reset (reset),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_data),
    .raddr (idx_q),
    .rd_en (de_dly_q[1]),
    .rdata (rgb_out)
  );

  assign fb_rd_addr = addr_q;
  assign swap_ack   = ack_q;
  assign back_buf   = ~front_q;
  assign hsync_out  = hs_dly_q[PIPE_LAT-1];
  assign vsync_out  = vs_dly_q[PIPE_LAT-1];
  assign de_out     = de_dly_q[PIPE_LAT-1];

endmodule
